// File: rtl/event_stretcher.sv
// Multi-channel event stretcher: trigger -> clean pulse of LEN cycles
// with edge/level trigger, retrigger or one-shot, hold-off, drop flag.
// clk, rst (async, active-low)
// in[CH]       : per-channel event inputs
// out[CH]      : stretched pulse (registered)
// start[CH]    : one-cycle strobe when out rises from 0
// dropped[CH]  : sticky flag, a trigger was ignored
// drop_clr[CH] : synchronous clear of dropped (set wins)
module event_stretcher #(
  parameter int CH      = 4,
  parameter int LEN     = 4,
  parameter int HOLDOFF = 0,
  parameter int EDGE    = 0,
  parameter int RETRIG  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] start,
  output logic [CH-1:0] dropped,
  input  logic [CH-1:0] drop_clr
);

  localparam int MAXV = (LEN > HOLDOFF) ? LEN : HOLDOFF;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] PLOAD = CW'(LEN - 1);
  localparam logic [CW-1:0] HLOAD =
    CW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [CH-1:0] in_q;
  logic [CH-1:0] trig;
  logic [CH-1:0] drop_set;
  logic [1:0]    st  [CH];
  logic [CW-1:0] cnt [CH];

  always_comb begin
    trig = (EDGE != 0) ? (in & ~in_q) : in;
  end

  // A trigger is lost in HOLD, or in PULSE when reload is disabled.
  always_comb begin
    drop_set = '0;
    for (int i = 0; i < CH; i++) begin
      drop_set[i] = trig[i] &
        ((st[i] == HOLD) |
         ((st[i] == PULSE) & (RETRIG == 0)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q    <= '0;
      out     <= '0;
      start   <= '0;
      dropped <= '0;
      for (int i = 0; i < CH; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= ZERO;
      end
    end else begin
      in_q    <= in;
      start   <= '0;
      dropped <= (dropped & ~drop_clr) | drop_set;
      for (int i = 0; i < CH; i++) begin
        unique case (1'b1)
          (st[i] == IDLE): begin
            if (trig[i]) begin
              st[i]    <= PULSE;
              out[i]   <= 1'b1;
              start[i] <= 1'b1;
              cnt[i]   <= PLOAD;
            end else begin
              out[i] <= 1'b0;
            end
          end
          (st[i] == PULSE): begin
            if (trig[i] && (RETRIG != 0)) begin
              cnt[i] <= PLOAD;
              out[i] <= 1'b1;
            end else if (cnt[i] != ZERO) begin
              cnt[i] <= cnt[i] - ONE;
            end else begin
              out[i] <= 1'b0;
              if (HOLDOFF > 0) begin
                st[i]  <= HOLD;
                cnt[i] <= HLOAD;
              end else begin
                st[i] <= IDLE;
              end
            end
          end
          (st[i] == HOLD): begin
            out[i] <= 1'b0;
            if (cnt[i] != ZERO) begin
              cnt[i] <= cnt[i] - ONE;
            end else begin
              st[i] <= IDLE;
            end
          end
          default: begin
            st[i]  <= IDLE;
            out[i] <= 1'b0;
            cnt[i] <= ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_event_stretcher.sv
// Directed bench for event_stretcher: three configurations
// (retrigger/level, one-shot with hold-off, edge-triggered).
module tb_event_stretcher;

  logic       clk;
  logic       rst;
  logic [3:0] in_a, in_b, in_c;
  logic [3:0] clr_a, clr_b, clr_c;
  logic [3:0] out_a, out_b, out_c;
  logic [3:0] st_a, st_b, st_c;
  logic [3:0] dr_a, dr_b, dr_c;

  int checks = 0;
  int fails  = 0;

  event_stretcher #(
    .CH(4), .LEN(4), .HOLDOFF(0), .EDGE(0), .RETRIG(1)
  ) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a),
    .start(st_a), .dropped(dr_a), .drop_clr(clr_a)
  );

  event_stretcher #(
    .CH(4), .LEN(4), .HOLDOFF(3), .EDGE(0), .RETRIG(0)
  ) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b),
    .start(st_b), .dropped(dr_b), .drop_clr(clr_b)
  );

  event_stretcher #(
    .CH(4), .LEN(4), .HOLDOFF(0), .EDGE(1), .RETRIG(1)
  ) dut_c (
    .clk(clk), .rst(rst), .in(in_c), .out(out_c),
    .start(st_c), .dropped(dr_c), .drop_clr(clr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst   = 1'b0;
    in_a  = '0; in_b  = '0; in_c  = '0;
    clr_a = '0; clr_b = '0; clr_c = '0;
    #2;
    chk("rst_out_a", out_a, 4'b0000);
    chk("rst_start_a", st_a, 4'b0000);
    chk("rst_drop_b", dr_b, 4'b0000);
    idle(2);
    rst = 1'b1;
    idle(2);

    // single pulse, LEN=4
    in_a = 4'b0001;
    tick();
    chk("a1_out0", out_a, 4'b0001);
    chk("a1_st0", st_a, 4'b0001);
    in_a = 4'b0000;
    tick();
    chk("a1_out1", out_a, 4'b0001);
    chk("a1_st1", st_a, 4'b0000);
    tick();
    chk("a1_out2", out_a, 4'b0001);
    tick();
    chk("a1_out3", out_a, 4'b0001);
    tick();
    chk("a1_out4", out_a, 4'b0000);
    idle(3);

    // retrigger extends seamlessly
    in_a = 4'b0001;
    tick();
    in_a = 4'b0000;
    chk("a2_st0", st_a, 4'b0001);
    tick();
    tick();
    in_a = 4'b0001;
    tick();
    in_a = 4'b0000;
    chk("a2_out3", out_a, 4'b0001);
    chk("a2_st3", st_a, 4'b0000);
    tick();
    chk("a2_out4", out_a, 4'b0001);
    tick();
    chk("a2_out5", out_a, 4'b0001);
    tick();
    chk("a2_out6", out_a, 4'b0001);
    tick();
    chk("a2_out7", out_a, 4'b0000);
    chk("a2_drop", dr_a, 4'b0000);
    idle(3);

    // one-shot with hold-off 3
    in_b = 4'b0001;
    tick();
    in_b = 4'b0000;
    chk("b_out0", out_b, 4'b0001);
    chk("b_st0", st_b, 4'b0001);
    tick();
    chk("b_drop1", dr_b, 4'b0000);
    in_b = 4'b0001;
    tick();
    in_b = 4'b0000;
    chk("b_out2", out_b, 4'b0001);
    chk("b_drop2", dr_b, 4'b0001);
    chk("b_st2", st_b, 4'b0000);
    clr_b = 4'b0001;
    tick();
    clr_b = 4'b0000;
    chk("b_out3", out_b, 4'b0001);
    chk("b_clr3", dr_b, 4'b0000);
    tick();
    chk("b_out4", out_b, 4'b0000);
    tick();
    in_b = 4'b0001;
    tick();
    in_b = 4'b0000;
    chk("b_hold6", out_b, 4'b0000);
    chk("b_drop6", dr_b, 4'b0001);
    tick();
    chk("b_out7", out_b, 4'b0000);
    tick();
    in_b = 4'b0001;
    tick();
    in_b = 4'b0000;
    chk("b_out9", out_b, 4'b0001);
    chk("b_st9", st_b, 4'b0001);
    tick();
    tick();
    tick();
    chk("b_out12", out_b, 4'b0001);
    tick();
    chk("b_out13", out_b, 4'b0000);
    clr_b = 4'b1111;
    idle(6);
    clr_b = 4'b0000;
    tick();
    chk("b_idle_drop", dr_b, 4'b0000);

    // edge mode: held-high input gives one pulse
    in_c = 4'b0010;
    tick();
    chk("c_out0", out_c, 4'b0010);
    chk("c_st0", st_c, 4'b0010);
    tick(); tick(); tick();
    chk("c_out3", out_c, 4'b0010);
    tick();
    chk("c_out4", out_c, 4'b0000);
    idle(15);
    chk("c_out19", out_c, 4'b0000);
    chk("c_st19", st_c, 4'b0000);
    chk("c_drop", dr_c, 4'b0000);
    in_c = 4'b0000;
    idle(2);

    // drop set beats clear on the same edge
    in_b = 4'b0100;
    tick();
    tick();
    chk("d_set", dr_b, 4'b0100);
    clr_b = 4'b0100;
    tick();
    in_b  = 4'b0000;
    chk("d_setwins", dr_b, 4'b0100);
    tick();
    clr_b = 4'b0000;
    chk("d_clr", dr_b, 4'b0000);
    idle(8);

    // async reset mid-pulse
    in_a = 4'b1111;
    in_b = 4'b0001;
    tick();
    in_a = 4'b0000;
    tick();
    in_b = 4'b0000;
    chk("r_pre_out", out_a, 4'b1111);
    chk("r_pre_drop", dr_b, 4'b0001);
    in_c = 4'b0010;
    rst  = 1'b0;
    #1;
    chk("r_out_a", out_a, 4'b0000);
    chk("r_out_b", out_b, 4'b0000);
    chk("r_drop_b", dr_b, 4'b0000);
    idle(2);
    rst = 1'b1;
    tick();
    chk("r_edge_c", out_c, 4'b0010);
    chk("r_a_idle", out_a, 4'b0000);
    in_c = 4'b0000;
    in_a = 4'b0001;
    tick();
    in_a = 4'b0000;
    chk("r_out0", out_a, 4'b0001);
    chk("r_st0", st_a, 4'b0001);
    tick(); tick(); tick();
    chk("r_out3", out_a, 4'b0001);
    tick();
    chk("r_out4", out_a, 4'b0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
